shift_encoding_seq: RTL and testbench

Multi-cycle sequencer that performs the team's key-driven byte-scatter vote encoding one step per clock, replacing the wide single-cycle permutation network. It captures an 80-bit record and a 64-bit final key with a valid/ready handshake, derives start and step from the key, then scatters the 10 record bytes into an output buffer. It sits between the ballot record builder and the storage/transmit path, and presents the result with a valid/ready handshake.

---
 rtl/shift_encoding_seq.sv | 135 +++++++++++++
 tb/tb_shift_encoding_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_encoding_seq.sv
// Multi-cycle key-driven byte-scatter encoder: captures an 80-bit record and a 64-bit key,
// derives start/step from the key and scatters one record byte per clock into the output buffer.
module shift_encoding_seq #(
    parameter bit SERIAL_KEY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:79] data_in,
    input  logic [0:63] final_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:79] data_out,
    output logic        overwrite,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a record/key handshake
    // KEY   | summing one key byte per cycle (SERIAL_KEY only)
    // PREP  | derive start and step from the key
    // SCAT  | write record byte k to position tmp % 10
    // DONE  | result presented until consumer accepts
    typedef enum logic [2:0] {IDLE, KEY, PREP, SCAT, DONE} state_t;

    state_t      state_q;
    logic [0:79] rec_q;
    logic [0:63] key_q;
    logic [0:79] buf_q;
    logic [9:0]  mask_q;
    logic [7:0]  sum_q;
    logic [7:0]  tmp_q;
    logic [7:0]  step_q;
    logic [3:0]  cnt_q;
    logic        ovw_q;
    logic        out_valid_q;

    logic [7:0]  sum_all;
    logic [7:0]  sum_d;
    logic [7:0]  raw;
    logic [7:0]  odd;
    logic [7:0]  step_d;
    logic [7:0]  start_d;
    logic [3:0]  idx;
    logic [7:0]  key_byte;
    logic [7:0]  rec_byte;

    always_comb begin
        sum_all = 8'd0;
        for (int m = 0; m < 8; m++) begin
            sum_all = sum_all + key_q[8*m +: 8];
        end
        sum_d    = SERIAL_KEY ? sum_q : sum_all;
        start_d  = sum_d % 8'd10;
        raw      = key_q[0:7];
        odd      = raw | 8'h01;
        // step is forced odd and never a multiple of 5, modulo 8-bit wrap
        step_d   = ((odd % 8'd5) == 8'd0) ? odd + 8'd2 : odd;
        idx      = 4'(tmp_q % 8'd10);
        key_byte = key_q[{cnt_q[2:0], 3'b000} +: 8];
        rec_byte = rec_q[{cnt_q, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rec_q       <= '0;
            key_q       <= '0;
            buf_q       <= '0;
            mask_q      <= '0;
            sum_q       <= '0;
            tmp_q       <= '0;
            step_q      <= '0;
            cnt_q       <= '0;
            ovw_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rec_q   <= data_in;
                        key_q   <= final_key;
                        buf_q   <= '0;
                        mask_q  <= '0;
                        sum_q   <= '0;
                        ovw_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SERIAL_KEY ? KEY : PREP;
                    end
                end
                KEY: begin
                    sum_q <= sum_q + key_byte;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    tmp_q   <= start_d;
                    step_q  <= step_d;
                    cnt_q   <= '0;
                    state_q <= SCAT;
                end
                SCAT: begin
                    buf_q[{idx, 3'b000} +: 8] <= rec_byte;
                    if (mask_q[idx]) begin
                        ovw_q <= 1'b1;
                    end
                    mask_q[idx] <= 1'b1;
                    tmp_q       <= tmp_q + step_q;
                    cnt_q       <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = buf_q;
    assign overwrite = ovw_q;

endmodule

// File: tb/tb_shift_encoding_seq.sv
// Randomized and directed bench for shift_encoding_seq against an arithmetic reference model.
module tb_shift_encoding_seq;

    localparam bit SERIAL_KEY = 1'b1;
    localparam int LAT        = SERIAL_KEY ? 19 : 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:79] data_in;
    logic [0:63] final_key;
    logic        out_valid;
    logic        out_ready;
    logic [0:79] data_out;
    logic        overwrite;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    shift_encoding_seq #(.SERIAL_KEY(SERIAL_KEY)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .final_key (final_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .overwrite (overwrite),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [0:79] d, input logic [0:63] k,
                                  output logic [0:79] o, output logic ow);
        int sum, start, raw, odd, step, idx;
        bit seen [10];
        sum = 0;
        for (int m = 0; m < 8; m++) sum = (sum + int'(k[8*m +: 8])) % 256;
        start = sum % 10;
        raw   = int'(k[0:7]);
        odd   = (raw % 2 == 0) ? raw + 1 : raw;
        step  = (odd % 5 == 0) ? (odd + 2) % 256 : odd;
        o  = '0;
        ow = 1'b0;
        for (int j = 0; j < 10; j++) seen[j] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            idx = ((start + j * step) % 256) % 10;
            if (seen[idx]) ow = 1'b1;
            seen[idx] = 1'b1;
            o[8*idx +: 8] = d[8*j +: 8];
        end
    endfunction

    function automatic logic [0:79] seq_bytes(input int base);
        logic [0:79] r;
        for (int i = 0; i < 10; i++) r[8*i +: 8] = 8'(base + i);
        return r;
    endfunction

    function automatic logic [0:79] rnd80();
        return 80'({$urandom, $urandom, $urandom});
    endfunction

    task automatic accept(input logic [0:79] d, input logic [0:63] k);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_wait", 80'(in_ready), 80'd1);
        data_in   = d;
        final_key = k;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = rnd80();
        final_key = 64'({$urandom, $urandom});
    endtask

    task automatic run_rec(input string tag, input logic [0:79] d, input logic [0:63] k,
                           input int hold, input logic [0:79] exp_ovr_data, input bit use_ovr,
                           input logic exp_ovr_ow);
        logic [0:79] e;
        logic        eo;
        int          lat;
        model(d, k, e, eo);
        if (use_ovr) begin
            chk({tag, "_model"}, e, exp_ovr_data);
            chk({tag, "_model_ow"}, 80'(eo), 80'(exp_ovr_ow));
        end
        out_ready = 1'b0;
        accept(d, k);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 80'(lat), 80'(LAT));
        chk({tag, "_data"}, data_out, e);
        chk({tag, "_ovw"}, 80'(overwrite), 80'(eo));
        for (int h = 0; h < hold; h++) begin
            data_in = rnd80();
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 80'(out_valid), 80'd1);
            chk({tag, "_hold_data"}, data_out, e);
            chk({tag, "_hold_inrdy"}, 80'(in_ready), 80'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 80'(out_valid), 80'd0);
        chk({tag, "_drop_inrdy"}, 80'(in_ready), 80'd1);
    endtask

    initial begin
        logic [0:63] k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        final_key = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 80'(out_valid), 80'd0);
        chk("rst_data", data_out, 80'd0);
        chk("rst_ovw", 80'(overwrite), 80'd0);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_inrdy", 80'(in_ready), 80'd1);

        run_rec("zero_key", seq_bytes(0), 64'h0, 0, seq_bytes(0), 1'b1, 1'b0);
        run_rec("key05", seq_bytes(0), 64'h05_00_00_00_00_00_00_00, 0,
                80'h05_08_01_04_07_00_03_06_09_02, 1'b1, 1'b0);
        run_rec("key7f", seq_bytes(8'h10), 64'h7F_00_00_00_00_00_00_00, 0,
                80'h15_16_13_14_11_18_19_10_17_00, 1'b1, 1'b1);
        run_rec("keyff", seq_bytes(0), 64'hFF_00_00_00_00_00_00_00, 0,
                80'h05_06_07_08_09_00_01_02_03_04, 1'b1, 1'b0);
        run_rec("hold5", seq_bytes(0), 64'h05_00_00_00_00_00_00_00, 5,
                80'h05_08_01_04_07_00_03_06_09_02, 1'b1, 1'b0);
        run_rec("after_hold", seq_bytes(8'h20), 64'h0, 0, seq_bytes(8'h20), 1'b1, 1'b0);

        // abort in the middle of scattering (k = 4)
        accept(rnd80(), 64'({$urandom, $urandom}));
        repeat (LAT - 6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_valid", 80'(out_valid), 80'd0);
        chk("abort_data", data_out, 80'd0);
        chk("abort_inrdy", 80'(in_ready), 80'd1);
        chk("abort_busy", 80'(busy), 80'd0);
        run_rec("post_abort", seq_bytes(0), 64'h7F_00_00_00_00_00_00_00, 0,
                '0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            k = 64'({$urandom, $urandom});
            if (i % 3 == 0) k[8:63] = '0;
            run_rec($sformatf("rnd%0d", i), rnd80(), k, $urandom_range(0, 3), '0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
